// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - microprogram sequencer driving the register-file/ALU control word
// Optional runaway watchdog (WD_LIMIT, wd_trip) enabled by defining DATAPATH_SEQ_WATCHDOG_EN.
module datapath_sequencer #(
  parameter int PC_W = 4,
  parameter int IW   = 20
`ifdef DATAPATH_SEQ_WATCHDOG_EN
  ,
  parameter int WD_LIMIT = 255
`endif
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  input  logic            step_mode,
  input  logic            step,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [IW-1:0]   prog_data,
  input  logic [3:0]      status,
  output logic [2:0]      SA,
  output logic [2:0]      SB,
  output logic [2:0]      DA,
  output logic [4:0]      FS,
  output logic            WR,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      flags,
  output logic            busy,
  output logic            done
`ifdef DATAPATH_SEQ_WATCHDOG_EN
  ,
  output logic            wd_trip
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WRITE, PAUSE} state_t;

  localparam logic [1:0]    K_ALU    = 2'b00;
  localparam logic [1:0]    K_BRANCH = 2'b01;
  localparam logic [1:0]    K_HALT   = 2'b10;
  localparam logic [1:0]    K_NOP    = 2'b11;
  localparam logic [IW-1:0] NOP_WORD = {K_NOP, {(IW-2){1'b0}}};

  state_t          state, state_next, resume;
  logic [PC_W-1:0] pc_next;
  logic [3:0]      flags_next;
  logic [IW-1:0]   ir;
  logic [IW-1:0]   mem [2**PC_W];
  logic [1:0]      kind;
  logic            taken;
  logic            run_start;

`ifdef DATAPATH_SEQ_WATCHDOG_EN
  localparam logic [7:0] WD_MAX = 8'(WD_LIMIT);
  logic [7:0] wd_count;
  logic       wd_hit;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    kind       = ir[IW-1:IW-2];
    // flags is {V,C,N,Z}, so select 0 (V) lives in bit 3
    taken      = ir[14] | (flags[2'd3 - ir[17:16]] ^ ir[15]);
    resume     = step_mode ? PAUSE : FETCH;
    state_next = state;
    pc_next    = pc;
    flags_next = flags;
    run_start  = 1'b0;
    SA         = 3'd0;
    SB         = 3'd0;
    DA         = 3'd0;
    FS         = 5'd0;
    WR         = 1'b0;
    done       = 1'b0;
`ifdef DATAPATH_SEQ_WATCHDOG_EN
    wd_hit     = 1'b0;
`endif
    if ((state == EXEC || state == WRITE) && kind == K_ALU) begin
      FS = ir[17:13];
      DA = ir[12:10];
      SA = ir[9:7];
      SB = ir[6:4];
    end
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          pc_next    = '0;
          run_start  = 1'b1;
        end
      end
      FETCH: begin
        state_next = EXEC;
`ifdef DATAPATH_SEQ_WATCHDOG_EN
        if (wd_count >= WD_MAX) begin
          state_next = IDLE;
          wd_hit     = 1'b1;
        end
`endif
      end
      EXEC: begin
        case (kind)
          K_ALU:    state_next = WRITE;
          K_BRANCH: begin
            pc_next    = taken ? ir[PC_W-1:0] : pc + 1'b1;
            state_next = resume;
          end
          K_HALT: begin
            done       = 1'b1;
            state_next = IDLE;
          end
          default: begin
            pc_next    = pc + 1'b1;
            state_next = resume;
          end
        endcase
      end
      WRITE: begin
        WR         = ir[3];
        flags_next = status;
        pc_next    = pc + 1'b1;
        state_next = resume;
      end
      PAUSE: begin
        if (step) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
    // stop aborts from anywhere and also blocks a start or a pending write
    if (stop) begin
      state_next = IDLE;
      pc_next    = pc;
      flags_next = flags;
      WR         = 1'b0;
      run_start  = 1'b0;
`ifdef DATAPATH_SEQ_WATCHDOG_EN
      wd_hit     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= '0;
      flags <= 4'd0;
      ir    <= NOP_WORD;
    end else begin
      pc    <= pc_next;
      flags <= flags_next;
      if (state == FETCH) ir <= mem[pc];
    end
  end

  // program memory survives reset; loader writes only while idle
  always_ff @(posedge clock) begin
    if (state == IDLE && prog_we) mem[prog_addr] <= prog_data;
  end

`ifdef DATAPATH_SEQ_WATCHDOG_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_count <= 8'd0;
      wd_trip  <= 1'b0;
    end else begin
      if (run_start) begin
        wd_count <= 8'd0;
        wd_trip  <= 1'b0;
      end else if (state == EXEC && wd_count != 8'hFF) begin
        wd_count <= wd_count + 8'd1;
      end
      if (wd_hit) wd_trip <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - scoreboard bench for datapath_sequencer (default build)
module tb_datapath_sequencer;
  localparam int PC_W = 4;
  localparam int IW   = 20;
  localparam logic [19:0] HALT_I = 20'h80000;
  localparam logic [19:0] NOP_I  = 20'hC0000;

  logic            clock = 1'b0;
  logic            reset, start, stop, step_mode, step, prog_we;
  logic [PC_W-1:0] prog_addr;
  logic [IW-1:0]   prog_data;
  logic [3:0]      status;
  logic [2:0]      SA, SB, DA;
  logic [4:0]      FS;
  logic            WR, busy, done;
  logic [PC_W-1:0] pc;
  logic [3:0]      flags;

  typedef struct {
    logic        is_done;
    logic [17:0] val;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  logic [6:0] wr_tr, done_tr;

  logic [3:0] bt_st  [7] = '{4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [1:0] bt_sel [7] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
  logic       bt_inv [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       bt_alw [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0] bt_pc  [7] = '{4'd7, 4'd2, 4'd7, 4'd7, 4'd7, 4'd2, 4'd2};

  datapath_sequencer #(.PC_W(PC_W), .IW(IW)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .step_mode(step_mode), .step(step), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .status(status),
    .SA(SA), .SB(SB), .DA(DA), .FS(FS), .WR(WR), .pc(pc),
    .flags(flags), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t wr_ev(input logic [2:0] da, input logic [2:0] sa, input logic [2:0] sb,
                                input logic [4:0] fs, input logic [3:0] p);
    ev_t e;
    e.is_done = 1'b0;
    e.val     = {da, sa, sb, fs, p};
    return e;
  endfunction

  function automatic ev_t done_ev(input logic [3:0] p, input logic [3:0] f);
    ev_t e;
    e.is_done = 1'b1;
    e.val     = {10'd0, p, f};
    return e;
  endfunction

  function automatic logic [19:0] alu_i(input logic [4:0] fs, input logic [2:0] da,
                                        input logic [2:0] sa, input logic [2:0] sb, input logic wr);
    return {2'b00, fs, da, sa, sb, wr, 3'b000};
  endfunction

  function automatic logic [19:0] br_i(input logic [1:0] sel, input logic inv, input logic alw,
                                       input logic [3:0] tgt);
    return {2'b01, sel, inv, alw, 10'd0, tgt};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [19:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200 && busy; k++) tick();
    chk(name, 32'(busy), 0);
  endtask

  task automatic run_prog(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(name);
  endtask

  // Monitor: every WR or done pulse must match the oldest expected event
  always @(negedge clock) begin : monitor
    ev_t e;
    logic [18:0] act;
    if (!reset && (WR || done)) begin
      act = done ? {1'b1, 10'd0, pc, flags} : {1'b0, DA, SA, SB, FS, pc};
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got %0h expected none", act);
      end else begin
        e = q.pop_front();
        chk("scoreboard_event", 32'(act), 32'({e.is_done, e.val}));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; step_mode = 1'b0; step = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; status = 4'd0;
    tick();
    tick();
    @(negedge clock);
    chk("rst_outputs", 32'({SA, SB, DA, FS, WR, done, busy}), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_flags", 32'(flags), 0);
    tick();
    reset = 1'b0;
    tick();

    // ALU then HALT: WR at cycle 3, done at cycle 5
    load(4'd0, alu_i(5'd0, 3'd1, 3'd0, 3'd0, 1'b1));
    load(4'd1, HALT_I);
    q.push_back(wr_ev(3'd1, 3'd0, 3'd0, 5'd0, 4'd0));
    q.push_back(done_ev(4'd1, 4'd0));
    start = 1'b1;
    @(negedge clock);
    wr_tr[0] = WR; done_tr[0] = done;
    tick();
    start = 1'b0;
    for (int i = 1; i < 7; i++) begin
      @(negedge clock);
      wr_tr[i] = WR; done_tr[i] = done;
    end
    chk("basic_wr_cycle", 32'(wr_tr), 8);
    chk("basic_done_cycle", 32'(done_tr), 32);
    chk("basic_busy_after", 32'(busy), 0);
    tick();

    // stop during the WRITE of the ALU at pc=2
    load(4'd0, NOP_I);
    load(4'd1, NOP_I);
    load(4'd2, alu_i(5'd3, 3'd2, 3'd1, 3'd3, 1'b1));
    load(4'd3, HALT_I);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    stop = 1'b1;
    @(negedge clock);
    chk("stop_wr_gated", 32'(WR), 0);
    tick();
    stop = 1'b0;
    chk("stop_idle", 32'(busy), 0);
    chk("stop_pc", 32'(pc), 2);

    // branch condition table
    load(4'd0, alu_i(5'd2, 3'd4, 3'd5, 3'd6, 1'b1));
    load(4'd2, HALT_I);
    load(4'd7, HALT_I);
    for (int t = 0; t < 7; t++) begin
      load(4'd1, br_i(bt_sel[t], bt_inv[t], bt_alw[t], 4'd7));
      status = bt_st[t];
      q.push_back(wr_ev(3'd4, 3'd5, 3'd6, 5'd2, 4'd0));
      q.push_back(done_ev(bt_pc[t], bt_st[t]));
      run_prog("branch_idle");
      chk("branch_pc", 32'(pc), 32'(bt_pc[t]));
      chk("branch_flags", 32'(flags), 32'(bt_st[t]));
    end

    // single-step mode
    load(4'd0, NOP_I);
    load(4'd1, alu_i(5'd7, 3'd3, 3'd2, 3'd1, 1'b1));
    load(4'd2, NOP_I);
    load(4'd3, HALT_I);
    status = 4'b0110;
    step_mode = 1'b1;
    q.push_back(wr_ev(3'd3, 3'd2, 3'd1, 5'd7, 4'd1));
    q.push_back(done_ev(4'd3, 4'b0110));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("step_pause_pc1", 32'(pc), 1);
    chk("step_busy1", 32'(busy), 1);
    step = 1'b1; tick(); step = 1'b0;
    repeat (5) tick();
    chk("step_pause_pc2", 32'(pc), 2);
    chk("step_busy2", 32'(busy), 1);
    step = 1'b1; tick(); step = 1'b0;
    repeat (5) tick();
    chk("step_pause_pc3", 32'(pc), 3);
    chk("step_busy3", 32'(busy), 1);
    step = 1'b1; tick(); step = 1'b0;
    wait_idle("step_idle");
    step_mode = 1'b0;

    // pc wrap 15->0; loader writes during the run must be ignored
    chk("wrap_pre_flags", 32'(flags), 32'(4'b0110));
    load(4'd0, br_i(2'd3, 1'b1, 1'b0, 4'd14));
    load(4'd1, HALT_I);
    load(4'd14, alu_i(5'd9, 3'd7, 3'd6, 3'd5, 1'b1));
    load(4'd15, NOP_I);
    status = 4'b0001;
    q.push_back(wr_ev(3'd7, 3'd6, 3'd5, 5'd9, 4'd14));
    q.push_back(done_ev(4'd1, 4'b0001));
    start = 1'b1;
    tick();
    start = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = HALT_I;
    repeat (3) tick();
    prog_we = 1'b0;
    wait_idle("wrap_idle");
    chk("wrap_pc", 32'(pc), 1);

    // start with simultaneous load, held start restarts after done
    q.push_back(done_ev(4'd0, 4'b0001));
    q.push_back(done_ev(4'd0, 4'b0001));
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = HALT_I;
    start = 1'b1;
    tick();
    prog_we = 1'b0;
    repeat (5) tick();
    start = 1'b0;
    tick();
    chk("restart_idle", 32'(busy), 0);

    // reset during EXEC aborts with no write
    load(4'd0, alu_i(5'd1, 3'd1, 3'd1, 3'd1, 1'b1));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_pc", 32'(pc), 0);
    chk("midrst_flags", 32'(flags), 0);
    repeat (4) tick();

    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Microprogram sequencer that drives the 8x16 register file / 16-bit ALU datapath control word (SA, SB, DA, FS, WR) from an internal program memory.
- Replaces hand-toggled switches/button clock with an automatic run or single-step engine; branches on captured VCNZ status.
- Sits between board I/O (start/step/stop buttons, program loader) and the register file/ALU pair; its outputs also feed the VGA debug display.

Parameters:
- PC_W, 4, program counter width; program depth = 2**PC_W words.
- IW, 20, micro-instruction width (fixed format below; must be 20).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  level; begin run at pc=0 when IDLE
- stop  in  1  abort run
- step_mode  in  1  1 = pause after each instruction
- step  in  1  single-cycle pulse; resume from PAUSE
- prog_we  in  1  program memory write enable
- prog_addr  in  PC_W  program write address
- prog_data  in  IW  program write data
- status  in  4  ALU status {V,C,N,Z}
- SA  out  3  A-bus source register
- SB  out  3  B-bus source register
- DA  out  3  destination register
- FS  out  5  ALU function select
- WR  out  1  register file write enable
- pc  out  PC_W  current program counter
- flags  out  4  last captured {V,C,N,Z}
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on HALT completion

Behaviour:
- Instruction format: [19:18] kind: 00 ALU, 01 BRANCH, 10 HALT, 11 NOP.
- ALU: [17:13] FS, [12:10] DA, [9:7] SA, [6:4] SB, [3] wr; [2:0] ignored.
- BRANCH: [17:16] flag select (0=V,1=C,2=N,3=Z), [15] invert, [14] always; [PC_W-1:0] target. Taken if always | (flags[sel] ^ invert).
- States: IDLE, FETCH, EXEC, WRITE, PAUSE.
- IDLE: start=1 -> pc<=0, FETCH.
- FETCH: registered read of mem[pc] into ir -> EXEC.
- EXEC: drive SA/SB/DA/FS from ir (ALU only; other kinds drive 0).
  - ALU -> WRITE.
  - BRANCH: pc<=target if taken else pc+1; -> next.
  - NOP: pc+1; -> next.
  - HALT: done=1 for this cycle, pc unchanged -> IDLE.
- WRITE: SA/SB/DA/FS held; WR=ir.wr for exactly this cycle; flags<=status (captured even if wr=0); pc<=pc+1; -> next.
- "next" = PAUSE if step_mode else FETCH.
- PAUSE: step=1 -> FETCH. stop also exits to IDLE.
- Latency: ALU 3 cycles, BRANCH/NOP 2 cycles, HALT 2 cycles start-to-done.
- pc increments wrap modulo 2**PC_W (pc=15 + 1 -> 0).
- stop=1 in any non-IDLE state -> IDLE next cycle. WR is combinationally gated by ~stop, so a WRITE cycle coinciding with stop performs no write. stop has priority over step and start.
- start while busy: ignored. start held in IDLE after done: restarts.
- prog_we is honoured only in IDLE; ignored otherwise. A simultaneous start and prog_we in IDLE: write occurs, run starts, and the first FETCH sees the new word.
- Reset: state=IDLE, pc=0, flags=0, ir=NOP, SA/SB/DA/FS=0, WR=0, busy=0, done=0. Program memory is not cleared. Reset mid-run aborts with no WR pulse.

Optional Feature:
- Macro DATAPATH_SEQ_WATCHDOG_EN.
- With it: adds parameter WD_LIMIT (default 255), an 8-bit executed-instruction counter cleared on start, and output wd_trip (1 bit).
  - Counter increments on every EXEC.
  - When count reaches WD_LIMIT, the next FETCH instead goes to IDLE and wd_trip=1.
  - wd_trip is sticky until reset or next start; done is not pulsed on trip.
- Without it: no counter, no wd_trip port; runaway loops run until stop.

Test Plan:
- Load mem[0]=ALU FS=00000 DA=1 SA=0 SB=0 wr=1, mem[1]=HALT; start -> WR high exactly one cycle at cycle 3 with DA=1, done pulse at cycle 5, busy low after.
- ALU wr=1 at pc=2 with stop asserted during its WRITE cycle -> WR stays 0, state IDLE next cycle, pc=2.
- status=4'b0001 at ALU WRITE, then BRANCH sel=Z invert=0 target=7 -> flags=0001, pc=7; same with invert=1 -> pc=next.
- step_mode=1, 3-instruction program -> PAUSE after each instruction, pc advances only after step pulses, busy=1 throughout.
- NOP at pc=15 with mem[0]=HALT -> pc wraps to 0, done pulses; prog_we during run to addr 0 -> memory unchanged.
- With DATAPATH_SEQ_WATCHDOG_EN, WD_LIMIT=4, mem[0]=BRANCH always target 0 -> after 4 EXECs state IDLE, wd_trip=1, done never pulses.
